fcvt_wb_queue: RTL and testbench
================================

Name: fcvt_wb_queue

Overview:
- Writeback buffer directly downstream of the combinational int32-to-float32 converter.
- Captures the converter result, destination register index and inexact flag in a 2-entry FIFO.
- Presents results to the FP register-file write port over a valid/ready handshake.
- Accrues the NX exception flag into a sticky fflags register, which the CSR unit can read and overwrite.

Parameters:
- F_WIDTH, 32, float result width.
- R_ADDR, 5, FP destination register index width.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  converter result valid.
- in_ready  output  1  queue can accept an entry.
- in_data  input  F_WIDTH  converted float {sign, exp, frac}.
- in_rd  input  R_ADDR  destination FP register.
- in_inexact  input  1  converter inexact flag.
- wb_valid  output  1  head entry valid.
- wb_ready  input  1  register file accepts the write.
- wb_data  output  F_WIDTH  head entry data.
- wb_rd  output  R_ADDR  head entry register index.
- flush  input  1  pipeline kill; discard all queued entries.
- csr_fflags_we  input  1  CSR write to fflags.
- csr_fflags_wdata  input  5  CSR write value {NV, DZ, OF, UF, NX}.
- fflags  output  5  sticky accrued flags; bit 0 is NX.

Behaviour:
- Reset (RST=1 at a rising edge):
  - count, read pointer and write pointer go to 0.
  - Storage is cleared to 0, so wb_data=0 and wb_rd=0.
  - fflags goes to 0; wb_valid=0; in_ready=1.
  - Reset overrides flush, pushes and CSR writes in the same cycle.
- Storage: circular buffer of DEPTH entries {data, rd, inexact}, with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits wide.
- Status outputs:
  - in_ready = (count != DEPTH), decoded from registered count only.
  - in_ready does not depend on wb_ready, so there is no combinational ready path.
  - wb_valid = (count != 0); wb_data and wb_rd come from the entry at the read pointer.
- Push: in_valid & in_ready & ~flush. The entry is written at the write pointer and the write pointer increments.
- Pop: wb_valid & wb_ready. The read pointer increments.
- Latency: no bypass.
  - An entry pushed in cycle N is visible on wb_* in cycle N+1 at the earliest.
  - Throughput is 1 entry per cycle when wb_ready is held high.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, in_ready=0, so no push can coincide with a pop; the freed slot is usable from the next cycle.
- Ordering: strict FIFO. Head outputs are stable while wb_valid=1 and wb_ready=0.
- Flush:
  - A pop in the flush cycle completes normally, because the register file sees the handshake; it accrues NX.
  - The next cycle has count=0 and pointers equal.
  - A push in the flush cycle is dropped.
  - Dropped entries never accrue NX.
- fflags update, evaluated each cycle with nx_ret = pop & head.inexact:
  - csr_fflags_we=1: fflags_next = csr_fflags_wdata | {4'b0, nx_ret}. A retiring NX is never lost.
  - Otherwise: fflags_next = fflags | {4'b0, nx_ret}.
  - Bits 4:1 change only via CSR write or reset.
  - fflags is a registered output; it reflects a retirement one cycle after the pop.
- Invariants the bench checks each cycle:
  - count never exceeds DEPTH.
  - wb_valid=0 implies no pop.
  - Pointers are equal exactly when count is 0 or DEPTH.

Test Plan:
- Single pass: push {0x3F800000, rd=3, nx=0} with wb_ready=1. Required: wb_valid one cycle later with wb_data=0x3F800000 and wb_rd=3, popped, and fflags stays 0x00.
- NX accrual: push {0x4B800000, rd=7, nx=1}, i.e. int 16777217 truncated. Required: after the pop, fflags=0x01 on the next cycle; a following nx=0 entry leaves it at 0x01.
- Backpressure and full:
  - With wb_ready=0, push A=0x40000000 then B=0x40400000. Required: in_ready=0 after two pushes; a third offered entry is not accepted; wb_data holds A stably.
  - Raise wb_ready. Required: A, then B pop in order, then wb_valid=0.
- Simultaneous push/pop: with count=1 and wb_ready=1, push continuously for 8 cycles with alternating data. Required: count stays 1, the output stream matches the input with a 1-cycle lag, and pointers wrap correctly.
- Flush:
  - Fill 2 entries, both nx=1, with wb_ready=0. Assert flush for one cycle with in_valid=1. Required: next cycle wb_valid=0 and in_ready=1, fflags=0x00, and the offered entry is absent.
  - Repeat with wb_ready=1 during flush. Required: the head pops and fflags=0x01.
- CSR collision:
  - fflags=0x11; in one cycle csr_fflags_we=1, wdata=0x04, and a popped entry has nx=1. Required: fflags=0x05.
  - Repeat with nx=0. Required: fflags=0x04.
  - Assert RST mid-stream. Required: all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/fcvt_wb_queue.sv
// Writeback buffer between the int-to-float converter and the FP register file.
// Holds up to DEPTH results and accrues the NX flag of retired entries into fflags.
module fcvt_wb_queue #(
  parameter int F_WIDTH = 32,
  parameter int R_ADDR  = 5,
  parameter int DEPTH   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [F_WIDTH-1:0] in_data,
  input  logic [R_ADDR-1:0]  in_rd,
  input  logic               in_inexact,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [F_WIDTH-1:0] wb_data,
  output logic [R_ADDR-1:0]  wb_rd,
  input  logic               flush,
  input  logic               csr_fflags_we,
  input  logic [4:0]         csr_fflags_wdata,
  output logic [4:0]         fflags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [F_WIDTH-1:0] data_q [DEPTH];
  logic [R_ADDR-1:0]  rd_q   [DEPTH];
  logic               nx_q   [DEPTH];

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    fflags_q, fflags_d;

  logic push, pop, nx_ret;

  assign in_ready = (count_q != CW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign wb_data  = data_q[rptr_q];
  assign wb_rd    = rd_q[rptr_q];
  assign fflags   = fflags_q;

  assign push   = in_valid & in_ready & ~flush;
  assign pop    = wb_valid & wb_ready;
  assign nx_ret = pop & nx_q[rptr_q];

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push) wptr_d = wptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A pop in the flush cycle still retires; everything left behind is dropped.
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
    fflags_d = (csr_fflags_we ? csr_fflags_wdata : fflags_q) | {4'b0, nx_ret};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        nx_q[i]   <= 1'b0;
      end
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
      if (push) begin
        data_q[wptr_q] <= in_data;
        rd_q[wptr_q]   <= in_rd;
        nx_q[wptr_q]   <= in_inexact;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_wb_queue.sv
// Bench for fcvt_wb_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the writeback buffer.
module tb_fcvt_wb_queue;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_inexact;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        csr_fflags_we;
  logic [4:0]  csr_fflags_wdata;
  logic [4:0]  fflags;

  fcvt_wb_queue #(.F_WIDTH(32), .R_ADDR(5), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_rd(in_rd), .in_inexact(in_inexact),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .flush(flush), .csr_fflags_we(csr_fflags_we),
    .csr_fflags_wdata(csr_fflags_wdata), .fflags(fflags)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        nx;
  } ent_t;

  ent_t     mq[$];
  logic [4:0] ff_m;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the model, then advance both by one clock.
  task automatic step();
    bit   pop_m, push_m, nxr;
    ent_t e;
    chk("wb_valid", 64'(wb_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    chk("fflags",   64'(fflags),   64'(ff_m));
    chk("count",    64'(dut.count_q), 64'(mq.size()));
    chk("ptr_eq",   64'(dut.rptr_q == dut.wptr_q),
        64'(mq.size() == 0 || mq.size() == DEPTH));
    if (mq.size() != 0) begin
      chk("wb_data", 64'(wb_data), 64'(mq[0].d));
      chk("wb_rd",   64'(wb_rd),   64'(mq[0].rd));
    end
    pop_m  = (mq.size() != 0) && wb_ready;
    push_m = in_valid && (mq.size() < DEPTH) && !flush;
    nxr    = pop_m && mq[0].nx;
    e      = '{in_data, in_rd, in_inexact};
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      ff_m = 5'h0;
    end else begin
      ff_m = (csr_fflags_we ? csr_fflags_wdata : ff_m) | {4'b0, nxr};
      if (pop_m) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (push_m) mq.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    RST = 0; in_valid = 0; in_data = '0; in_rd = '0; in_inexact = 0;
    wb_ready = 0; flush = 0; csr_fflags_we = 0; csr_fflags_wdata = '0;
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] rd, input logic nx);
    in_valid = 1; in_data = d; in_rd = rd; in_inexact = nx;
  endtask

  task automatic csr_write(input logic [4:0] v);
    csr_fflags_we = 1; csr_fflags_wdata = v;
    step();
    csr_fflags_we = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    ff_m = 5'h0;
    chk("rst_wb_data", 64'(wb_data), 64'h0);
    chk("rst_wb_rd",   64'(wb_rd),   64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_fflags",  64'(fflags),  64'h0);

    // single pass
    wb_ready = 1;
    offer(32'h3F800000, 5'd3, 1'b0); step();
    in_valid = 0;
    chk("pass_valid", 64'(wb_valid), 64'h1);
    chk("pass_data", 64'(wb_data), 64'h3F800000);
    step(); step();
    chk("pass_ff", 64'(fflags), 64'h0);

    // NX accrual
    offer(32'h4B800000, 5'd7, 1'b1); step();
    in_valid = 0; step();
    chk("nx_acc", 64'(fflags), 64'h01);
    offer(32'h3F800000, 5'd1, 1'b0); step();
    in_valid = 0; step(); step();
    chk("nx_keep", 64'(fflags), 64'h01);

    // backpressure and full
    wb_ready = 0;
    offer(32'h40000000, 5'd1, 1'b0); step();
    offer(32'h40400000, 5'd2, 1'b0); step();
    chk("full_ready", 64'(in_ready), 64'h0);
    offer(32'h40800000, 5'd4, 1'b0); step(); step();
    chk("full_cnt", 64'(dut.count_q), 64'h2);
    chk("full_head", 64'(wb_data), 64'h40000000);
    in_valid = 0; wb_ready = 1; step();
    chk("order_b", 64'(wb_data), 64'h40400000);
    step();
    chk("drained", 64'(wb_valid), 64'h0);

    // simultaneous push/pop
    offer(32'hA5A5A5A5, 5'd9, 1'b0); step();
    for (int i = 0; i < 8; i++) begin
      offer((i % 2) ? 32'h5A5A5A00 + 32'(i) : 32'hA5A5A500 + 32'(i), 5'(i), 1'b0);
      step();
      chk("stream_cnt", 64'(dut.count_q), 64'h1);
    end
    in_valid = 0; step(); step();

    // flush with no pop
    csr_write(5'h00);
    wb_ready = 0;
    offer(32'h11111111, 5'd1, 1'b1); step();
    offer(32'h22222222, 5'd2, 1'b1); step();
    offer(32'h33333333, 5'd3, 1'b0); flush = 1; step();
    flush = 0; in_valid = 0;
    chk("fl_valid", 64'(wb_valid), 64'h0);
    chk("fl_ready", 64'(in_ready), 64'h1);
    chk("fl_ff",    64'(fflags),   64'h0);
    step();

    // flush with a retiring head
    offer(32'h44444444, 5'd4, 1'b1); step();
    offer(32'h55555555, 5'd5, 1'b1); step();
    offer(32'h66666666, 5'd6, 1'b0); flush = 1; wb_ready = 1; step();
    flush = 0; in_valid = 0;
    chk("flp_ff",    64'(fflags),   64'h01);
    chk("flp_valid", 64'(wb_valid), 64'h0);
    step();

    // CSR write colliding with an NX retirement
    csr_write(5'h11);
    wb_ready = 0;
    offer(32'h77777777, 5'd7, 1'b1); step();
    in_valid = 0; wb_ready = 1;
    csr_fflags_we = 1; csr_fflags_wdata = 5'h04; step();
    csr_fflags_we = 0;
    chk("csr_nx1", 64'(fflags), 64'h05);
    csr_write(5'h11);
    wb_ready = 0;
    offer(32'h88888888, 5'd8, 1'b0); step();
    in_valid = 0; wb_ready = 1;
    csr_fflags_we = 1; csr_fflags_wdata = 5'h04; step();
    csr_fflags_we = 0;
    chk("csr_nx0", 64'(fflags), 64'h04);

    // reset mid-stream
    wb_ready = 0;
    offer(32'h99999999, 5'd9, 1'b1); step();
    offer(32'hAAAAAAAA, 5'd10, 1'b1);
    RST = 1; csr_fflags_we = 1; csr_fflags_wdata = 5'h1F; step();
    idle();
    chk("rst2_valid", 64'(wb_valid), 64'h0);
    chk("rst2_ready", 64'(in_ready), 64'h1);
    chk("rst2_ff",    64'(fflags),   64'h0);
    chk("rst2_data",  64'(wb_data),  64'h0);
    chk("rst2_rd",    64'(wb_rd),    64'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid         = ($urandom_range(0, 3) != 0);
      in_data          = $urandom;
      in_rd            = 5'($urandom);
      in_inexact       = 1'($urandom);
      wb_ready         = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 15) == 0);
      csr_fflags_we    = ($urandom_range(0, 15) == 0);
      csr_fflags_wdata = 5'($urandom);
      RST              = ($urandom_range(0, 63) == 0);
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
